procyon_sync_filter: RTL and testbench

Multi-channel synchronizer with a per-channel glitch filter and edge detection. Each asynchronous input passes through an OPTN_SYNC_DEPTH flop chain. It then goes through a stability filter that only accepts a new level after OPTN_FILTER_CYCLES consecutive identical samples. Registered rise/fall pulses are produced for the filtered level. Used for external pins, buttons and slow status lines entering the core clock domain.

---
 rtl/procyon_sync_pkg.sv | 21 ++
 rtl/procyon_sync_filter_chan.sv | 97 +++++++++
 rtl/procyon_sync_filter.sv | 44 ++++
 tb/tb_procyon_sync_filter.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/procyon_sync_pkg.sv
// Shared types and helpers for the procyon synchronizer/glitch filter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package procyon_sync_pkg;

  // Widest stability counter any channel may use; the filter counter of a
  // channel never exceeds OPTN_FILTER_CYCLES-1, so upper bits stay zero.
  localparam int CNT_MAX_W = 16;

  // Bits needed to hold a count of 0..filter_cycles.
  function automatic int cnt_width(input int filter_cycles);
    return (filter_cycles < 1) ? 1 : $clog2(filter_cycles + 1);
  endfunction

  // Per-channel filter state: accepted level plus consecutive-mismatch count.
  typedef struct packed {
    logic                 level;
    logic [CNT_MAX_W-1:0] cnt;
  } filt_state_t;

endpackage

// File: rtl/procyon_sync_filter_chan.sv
// One channel: synchronizer chain, stability filter and registered edge pulses.
// Latency: OPTN_SYNC_DEPTH clocks to sync_o, plus OPTN_FILTER_CYCLES to filt_o.
// Backpressure: none; a new sample is accepted every clock.
module procyon_sync_filter_chan
  import procyon_sync_pkg::*;
#(
  parameter int   OPTN_SYNC_DEPTH    = 2,
  parameter int   OPTN_FILTER_CYCLES = 4,
  parameter logic OPTN_RESET_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  input  logic bypass_i,
  output logic sync_o,
  output logic filt_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CNT_W = cnt_width(OPTN_FILTER_CYCLES);
  localparam logic [CNT_MAX_W-1:0] CNT_LAST = CNT_MAX_W'(OPTN_FILTER_CYCLES - 1);

  // Reject configurations the filter cannot implement.
  if (OPTN_SYNC_DEPTH < 2) begin : g_bad_depth
    $error("procyon_sync_filter_chan: OPTN_SYNC_DEPTH must be >= 2");
  end
  if (OPTN_FILTER_CYCLES < 1) begin : g_bad_filter
    $error("procyon_sync_filter_chan: OPTN_FILTER_CYCLES must be >= 1");
  end
  if (CNT_W > CNT_MAX_W) begin : g_bad_cnt
    $error("procyon_sync_filter_chan: OPTN_FILTER_CYCLES too large for counter");
  end

  // Synchronizer flops; bit 0 is the metastability-catching stage.
  (* ASYNC_REG = "TRUE" *) logic [OPTN_SYNC_DEPTH-1:0] sync_q;
  logic [OPTN_SYNC_DEPTH-1:0] sync_d;
  logic                       sync_w;

  filt_state_t st_q, st_d;
  logic        rise_q, rise_d;
  logic        fall_q, fall_d;

  // Shift the asynchronous input one stage down the chain per clock.
  always_comb begin
    sync_d = {sync_q[OPTN_SYNC_DEPTH-2:0], async_i};
  end

  assign sync_w = sync_q[OPTN_SYNC_DEPTH-1];

  // Synchronizer chain register, reset to the channel's idle level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {OPTN_SYNC_DEPTH{OPTN_RESET_VAL}};
    end else begin
      sync_q <= sync_d;
    end
  end

  // Filter next state: accept a new level only after a full run of mismatches,
  // or immediately when bypassed; edges compare current and next level.
  always_comb begin
    st_d = st_q;
    if (bypass_i) begin
      st_d.level = sync_w;
      st_d.cnt   = '0;
    end else if (sync_w == st_q.level) begin
      st_d.cnt = '0;
    end else if (st_q.cnt == CNT_LAST) begin
      st_d.level = sync_w;
      st_d.cnt   = '0;
    end else begin
      st_d.cnt = st_q.cnt + 1'b1;
    end
    rise_d = ~st_q.level & st_d.level;
    fall_d = st_q.level & ~st_d.level;
  end

  // Filter state and edge pulse registers; reset drops any pending pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q   <= '{level: OPTN_RESET_VAL, cnt: '0};
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign sync_o = sync_w;
  assign filt_o = st_q.level;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/procyon_sync_filter.sv
// Multi-channel synchronizer with per-channel glitch filter and edge detect.
// Latency: OPTN_SYNC_DEPTH + OPTN_FILTER_CYCLES clocks from a clean input step.
// Backpressure: none; every channel samples its input every clock.
module procyon_sync_filter
  import procyon_sync_pkg::*;
#(
  parameter int                          OPTN_NUM_CHANNELS  = 4,
  parameter int                          OPTN_SYNC_DEPTH    = 2,
  parameter int                          OPTN_FILTER_CYCLES = 4,
  parameter logic [OPTN_NUM_CHANNELS-1:0] OPTN_RESET_VAL    = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [OPTN_NUM_CHANNELS-1:0] i_async_data,
  input  logic [OPTN_NUM_CHANNELS-1:0] i_bypass,
  output logic [OPTN_NUM_CHANNELS-1:0] o_sync_data,
  output logic [OPTN_NUM_CHANNELS-1:0] o_filt_data,
  output logic [OPTN_NUM_CHANNELS-1:0] o_rise,
  output logic [OPTN_NUM_CHANNELS-1:0] o_fall
);

  if (OPTN_NUM_CHANNELS < 1) begin : g_bad_channels
    $error("procyon_sync_filter: OPTN_NUM_CHANNELS must be >= 1");
  end

  // Channels are fully independent; one instance per input bit.
  for (genvar c = 0; c < OPTN_NUM_CHANNELS; c++) begin : g_chan
    procyon_sync_filter_chan #(
      .OPTN_SYNC_DEPTH    (OPTN_SYNC_DEPTH),
      .OPTN_FILTER_CYCLES (OPTN_FILTER_CYCLES),
      .OPTN_RESET_VAL     (OPTN_RESET_VAL[c])
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .async_i  (i_async_data[c]),
      .bypass_i (i_bypass[c]),
      .sync_o   (o_sync_data[c]),
      .filt_o   (o_filt_data[c]),
      .rise_o   (o_rise[c]),
      .fall_o   (o_fall[c])
    );
  end

endmodule

// File: tb/tb_procyon_sync_filter.sv
// Scoreboard bench: a window-based reference model predicts every output cycle.
module tb_procyon_sync_filter;

  localparam int          N  = 4;
  localparam int          D  = 2;
  localparam int          F  = 4;
  localparam logic [N-1:0] RV = 4'b1010;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] i_async_data = '0;
  logic [N-1:0] i_bypass = '0;
  logic [N-1:0] o_sync_data, o_filt_data, o_rise, o_fall;

  always #5 clk = ~clk;

  procyon_sync_filter #(
    .OPTN_NUM_CHANNELS  (N),
    .OPTN_SYNC_DEPTH    (D),
    .OPTN_FILTER_CYCLES (F),
    .OPTN_RESET_VAL     (RV)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_async_data (i_async_data),
    .i_bypass     (i_bypass),
    .o_sync_data  (o_sync_data),
    .o_filt_data  (o_filt_data),
    .o_rise       (o_rise),
    .o_fall       (o_fall)
  );

  typedef struct packed {
    logic [N-1:0] sync;
    logic [N-1:0] filt;
    logic [N-1:0] rise;
    logic [N-1:0] fall;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   mon_cyc  = 0;

  // Reference model state: input delay line, accepted levels, and a window
  // of the last F pre-edge synchronized samples with their bypass bits.
  logic [N-1:0] m_hist[$];
  logic [N-1:0] m_filt;
  logic [N-1:0] win_s[$];
  logic [N-1:0] win_b[$];

  // Predict the outputs visible after the next rising clock edge.
  task automatic model_edge(input logic [N-1:0] din, input logic [N-1:0] byp, input logic r);
    logic [N-1:0] sync_pre, fn, rise, fall;
    exp_t e;
    bit   ok;
    rise = '0;
    fall = '0;
    if (r) begin
      m_hist.delete();
      repeat (D) m_hist.push_back(RV);
      win_s.delete();
      win_b.delete();
      m_filt = RV;
    end else begin
      sync_pre = m_hist[D-1];
      win_s.push_back(sync_pre);
      win_b.push_back(byp);
      if (win_s.size() > F) begin
        void'(win_s.pop_front());
        void'(win_b.pop_front());
      end
      for (int c = 0; c < N; c++) begin
        if (byp[c]) begin
          fn[c] = sync_pre[c];
        end else begin
          // Accept only if the last F samples all differ, none bypassed.
          ok = (win_s.size() == F);
          foreach (win_s[j]) begin
            if (win_b[j][c] || (win_s[j][c] == m_filt[c])) ok = 0;
          end
          fn[c] = ok ? sync_pre[c] : m_filt[c];
        end
      end
      rise   = ~m_filt & fn;
      fall   = m_filt & ~fn;
      m_filt = fn;
      m_hist.push_front(din);
      void'(m_hist.pop_back());
    end
    e.sync = m_hist[D-1];
    e.filt = m_filt;
    e.rise = rise;
    e.fall = fall;
    exp_q.push_back(e);
  endtask

  task automatic cyc(input logic [N-1:0] din, input logic [N-1:0] byp, input logic r, input int n);
    repeat (n) begin
      @(negedge clk);
      i_async_data = din;
      i_bypass     = byp;
      rst          = r;
      model_edge(din, byp, r);
    end
  endtask

  task automatic cmp(input string name, input logic [N-1:0] got, input logic [N-1:0] expv);
    checks++;
    if (got !== expv) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%b expected=%b", name, mon_cyc, got, expv);
    end
  endtask

  // Monitor: every clock the DUT presents a new output set; pop and compare.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        mon_cyc++;
        cmp("sync_data", o_sync_data, e.sync);
        cmp("filt_data", o_filt_data, e.filt);
        cmp("rise",      o_rise,      e.rise);
        cmp("fall",      o_fall,      e.fall);
      end
    end
  end

  // Stimulus: directed scenarios followed by randomized toggling.
  initial begin
    logic [N-1:0] cur;
    logic [N-1:0] byp;
    int           hold[N];

    // Reset held with inputs opposite to the reset level, then release.
    cyc(4'b0101, 4'b0000, 1'b1, 3);
    cyc(4'b1010, 4'b0000, 1'b0, 4);

    // Clean rising step on ch0.
    cyc(4'b1011, 4'b0000, 1'b0, 10);

    // Settle all channels low, then a 3-cycle glitch and a 4-cycle pulse on ch1.
    cyc(4'b0000, 4'b0000, 1'b0, 10);
    cyc(4'b0010, 4'b0000, 1'b0, 3);
    cyc(4'b0000, 4'b0000, 1'b0, 8);
    cyc(4'b0010, 4'b0000, 1'b0, 4);
    cyc(4'b0000, 4'b0000, 1'b0, 10);

    // Bypass on ch2 with the input toggling every 2 cycles.
    for (int k = 0; k < 6; k++) begin
      cyc((k % 2 == 0) ? 4'b0100 : 4'b0000, 4'b0100, 1'b0, 2);
    end
    cyc(4'b0000, 4'b0100, 1'b0, 4);
    // Start a filtered count on ch2, bypass mid-count, then drop bypass.
    cyc(4'b0100, 4'b0000, 1'b0, 4);
    cyc(4'b0000, 4'b0100, 1'b0, 1);
    cyc(4'b0100, 4'b0000, 1'b0, 8);
    cyc(4'b0000, 4'b0000, 1'b0, 10);

    // ch0 rises while ch3 falls in the same cycle.
    cyc(4'b1000, 4'b0000, 1'b0, 10);
    cyc(4'b0001, 4'b0000, 1'b0, 10);

    // Reset during a partial count on ch0, then the full count again.
    cyc(4'b0000, 4'b0000, 1'b0, 10);
    cyc(4'b0001, 4'b0000, 1'b0, 4);
    cyc(4'b0001, 4'b0000, 1'b1, 1);
    cyc(4'b0001, 4'b0000, 1'b0, 10);

    // Random toggling with mixed short glitches, bypass flips and resets.
    cur = 4'b0001;
    byp = '0;
    for (int c = 0; c < N; c++) hold[c] = $urandom_range(1, 7);
    for (int k = 0; k < 1500; k++) begin
      for (int c = 0; c < N; c++) begin
        if (hold[c] == 0) begin
          cur[c]  = ~cur[c];
          hold[c] = $urandom_range(1, 7);
        end else begin
          hold[c]--;
        end
      end
      if ($urandom_range(0, 15) == 0) byp = byp ^ (N'(1) << $urandom_range(0, N-1));
      cyc(cur, byp, ($urandom_range(0, 199) == 0), 1);
    end
    cyc(cur, 4'b0000, 1'b0, 4);

    // Let the monitor drain, then confirm every prediction was consumed.
    repeat (2) @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d expected=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
